// File: rtl/move_legality_checker_if.sv
// rtl/move_legality_checker_if.sv - request/verdict and maze-memory signals of the move legality checker
interface move_legality_checker_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [4:0]        changedX;
  logic [4:0]        changedY;
  logic              forceReset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [1:0]        mem_data;
  logic              doneLegal;
  logic              isLegal;
  logic              scorePlusFive;
  logic              scoreMinusFive;
  logic              gameOver;
  logic              busy;

  // master is the datapath side, which also hosts the tile memory response
  modport master (
    output start, changedX, changedY, forceReset, mem_data,
    input  mem_addr, mem_rd, doneLegal, isLegal, scorePlusFive, scoreMinusFive, gameOver, busy
  );

  modport slave (
    input  start, changedX, changedY, forceReset, mem_data,
    output mem_addr, mem_rd, doneLegal, isLegal, scorePlusFive, scoreMinusFive, gameOver, busy
  );
endinterface

// File: rtl/move_legality_checker.sv
// rtl/move_legality_checker.sv - bounds-checks a candidate maze cell and classifies its tile
module move_legality_checker #(
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int ADDR_W      = 9,
  parameter int MEM_LATENCY = 1,
  parameter int EXIT_X      = 19,
  parameter int EXIT_Y      = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  move_legality_checker_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, BOUNDS, WAIT, DECIDE, DONE} state_t;

  state_t      state;
  logic [4:0]  x_q;
  logic [4:0]  y_q;
  logic [2:0]  cnt;
  logic        out_of_bounds;
  logic        at_exit;
  logic        tile_legal;
  logic [ADDR_W-1:0] cell_addr;

  // 6-bit compares so a 32-wide grid would not alias to zero
  assign out_of_bounds = ({1'b0, x_q} >= 6'(GRID_W)) || ({1'b0, y_q} >= 6'(GRID_H));
  assign at_exit       = (x_q == 5'(EXIT_X)) && (y_q == 5'(EXIT_Y));
  assign tile_legal    = (bus.mem_data != 2'b01);
  assign cell_addr     = ADDR_W'(y_q) * ADDR_W'(GRID_W) + ADDR_W'(x_q);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset || bus.forceReset) begin
      state              <= IDLE;
      x_q                <= '0;
      y_q                <= '0;
      cnt                <= '0;
      bus.mem_addr       <= '0;
      bus.mem_rd         <= 1'b0;
      bus.doneLegal      <= 1'b0;
      bus.isLegal        <= 1'b0;
      bus.scorePlusFive  <= 1'b0;
      bus.scoreMinusFive <= 1'b0;
      bus.gameOver       <= 1'b0;
    end else begin
      bus.doneLegal <= 1'b0;
      bus.mem_rd    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q                <= bus.changedX;
            y_q                <= bus.changedY;
            bus.isLegal        <= 1'b0;
            bus.scorePlusFive  <= 1'b0;
            bus.scoreMinusFive <= 1'b0;
            if (bus.gameOver) begin
              bus.doneLegal <= 1'b1;
              state         <= DONE;
            end else begin
              state <= BOUNDS;
            end
          end
        end
        BOUNDS: begin
          if (out_of_bounds) begin
            bus.doneLegal <= 1'b1;
            state         <= DONE;
          end else begin
            bus.mem_addr <= cell_addr;
            bus.mem_rd   <= 1'b1;
            cnt          <= 3'd1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // DECIDE samples mem_data exactly MEM_LATENCY edges after the read strobe
          if (cnt == 3'(MEM_LATENCY)) begin
            state <= DECIDE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DECIDE: begin
          bus.isLegal        <= tile_legal;
          bus.scorePlusFive  <= (bus.mem_data == 2'b10);
          bus.scoreMinusFive <= (bus.mem_data == 2'b11);
          if (tile_legal && at_exit) begin
            bus.gameOver <= 1'b1;
          end
          bus.doneLegal <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_move_legality_checker.sv
// tb/tb_move_legality_checker.sv - scoreboard bench for move_legality_checker
module tb_move_legality_checker;
  localparam int GRID_W = 20;
  localparam int GRID_H = 15;
  localparam int ADDR_W = 9;
  localparam int EXIT_X = 19;
  localparam int EXIT_Y = 14;

  typedef struct {
    int lat;
    bit legal;
    bit plus;
    bit minus;
    bit go;
    int rd;
    int addr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   start_cyc = 0;
  int   rd_seen = 0;
  exp_t sbq[$];

  bit m_legal, m_plus, m_minus, m_go;
  logic [1:0] maze [GRID_H][GRID_W];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  move_legality_checker_if #(.ADDR_W(ADDR_W)) bus ();

  move_legality_checker #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W),
    .MEM_LATENCY(1), .EXIT_X(EXIT_X), .EXIT_Y(EXIT_Y)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // one-cycle tile memory, decoded back into grid coordinates
  always @(posedge clock) begin
    int a;
    a = int'(bus.mem_addr);
    if (a < GRID_W * GRID_H) bus.mem_data <= maze[a / GRID_W][a % GRID_W];
    else                     bus.mem_data <= 2'b00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (bus.mem_rd) begin
        rd_seen++;
        if (sbq.size() == 0) check("mem_rd_unexpected", 1, 0);
        else begin
          check("mem_addr", bus.mem_addr, sbq[0].addr);
          check("mem_rd_cycle", cyc - start_cyc, 2);
        end
      end
      if (bus.doneLegal) begin
        if (sbq.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          check("latency", cyc - start_cyc, e.lat);
          check("isLegal", bus.isLegal, e.legal);
          check("scorePlusFive", bus.scorePlusFive, e.plus);
          check("scoreMinusFive", bus.scoreMinusFive, e.minus);
          check("gameOver", bus.gameOver, e.go);
          check("mem_rd_count", rd_seen, e.rd);
        end
      end
    end
  end

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    logic [1:0] tile;
    e = '{lat: 4, legal: 0, plus: 0, minus: 0, go: m_go, rd: 0, addr: 0};
    if (m_go) begin
      e.lat = 1;
    end else if (x >= GRID_W || y >= GRID_H) begin
      e.lat = 2;
    end else begin
      tile    = maze[y][x];
      e.rd    = 1;
      e.addr  = y * GRID_W + x;
      e.legal = (tile != 2'b01);
      e.plus  = (tile == 2'b10);
      e.minus = (tile == 2'b11);
      if (e.legal && x == EXIT_X && y == EXIT_Y) e.go = 1;
    end
    return e;
  endfunction

  task automatic issue(input int x, input int y, input bit junk);
    exp_t e;
    bit got;
    @(negedge clock);
    check("held_isLegal", bus.isLegal, m_legal);
    check("held_plus", bus.scorePlusFive, m_plus);
    check("held_minus", bus.scoreMinusFive, m_minus);
    check("held_gameOver", bus.gameOver, m_go);
    check("idle_busy", bus.busy, 0);
    e = model(x, y);
    m_legal = e.legal; m_plus = e.plus; m_minus = e.minus; m_go = e.go;
    sbq.push_back(e);
    start_cyc = cyc;
    rd_seen = 0;
    bus.start = 1'b1;
    bus.changedX = 5'(x);
    bus.changedY = 5'(y);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (i == 0 && junk) begin
        bus.changedX = 5'($urandom_range(0, 31));
        bus.changedY = 5'($urandom_range(0, 31));
      end else begin
        bus.start = 1'b0;
      end
      if (bus.doneLegal) got = 1;
    end
    bus.start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic force_reset(input bit with_start);
    @(negedge clock);
    bus.forceReset = 1'b1;
    bus.start = with_start;
    bus.changedX = 5'($urandom_range(0, 19));
    bus.changedY = 5'($urandom_range(0, 14));
    @(negedge clock);
    bus.forceReset = 1'b0;
    bus.start = 1'b0;
    m_legal = 0; m_plus = 0; m_minus = 0; m_go = 0;
    check("frst_busy", bus.busy, 0);
    check("frst_gameOver", bus.gameOver, 0);
    check("frst_isLegal", bus.isLegal, 0);
    @(negedge clock);
    check("frst_dropped_start", bus.busy, 0);
  endtask

  // forceReset while the read is outstanding: no verdict may appear
  task automatic abort_in_wait(input int x, input int y);
    exp_t e;
    if (m_go) force_reset(0);
    @(negedge clock);
    e = model(x, y);
    sbq.push_back(e);
    start_cyc = cyc;
    rd_seen = 0;
    bus.start = 1'b1;
    bus.changedX = 5'(x);
    bus.changedY = 5'(y);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.forceReset = 1'b1;
    @(negedge clock);
    bus.forceReset = 1'b0;
    void'(sbq.pop_back());
    m_legal = 0; m_plus = 0; m_minus = 0; m_go = 0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.doneLegal, 0);
    check("abort_gameOver", bus.gameOver, 0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int x, y, r;
    bus.start = 1'b0;
    bus.forceReset = 1'b0;
    bus.changedX = '0;
    bus.changedY = '0;
    for (int j = 0; j < GRID_H; j++)
      for (int i = 0; i < GRID_W; i++)
        maze[j][i] = 2'($urandom_range(0, 3));
    maze[0][2] = 2'b00;
    maze[1][1] = 2'b01;
    maze[5][5] = 2'b10;
    maze[5][6] = 2'b11;
    maze[EXIT_Y][EXIT_X] = 2'b00;
    m_legal = 0; m_plus = 0; m_minus = 0; m_go = 0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_doneLegal", bus.doneLegal, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_gameOver", bus.gameOver, 0);

    issue(2, 0, 0);
    issue(1, 1, 0);
    issue(31, 3, 0);
    issue(5, 5, 0);
    issue(6, 5, 1);
    issue(19, 14, 0);
    issue(3, 3, 0);
    issue(20, 0, 0);
    abort_in_wait(2, 0);
    issue(2, 0, 0);
    issue(0, 15, 0);
    issue(19, 14, 0);
    force_reset(1);
    issue(19, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) force_reset($urandom_range(0, 1));
      else if (r < 10) abort_in_wait($urandom_range(0, 19), $urandom_range(0, 14));
      else if (r < 14) issue(EXIT_X, EXIT_Y, 0);
      else begin
        if ($urandom_range(0, 3) != 0) begin
          x = $urandom_range(0, GRID_W - 1);
          y = $urandom_range(0, GRID_H - 1);
        end else begin
          x = $urandom_range(0, 31);
          y = $urandom_range(0, 31);
        end
        issue(x, y, $urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
